// File: rtl/line_pingpong_if.sv
// Pixel stream bundle for the ping-pong line buffer: input line stream plus
// the ready/valid output stream.
interface line_pingpong_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_eol;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_eol;

  modport master (
    output in_valid, in_data, in_eol, out_ready,
    input  out_valid, out_data, out_eol
  );

  modport slave (
    input  in_valid, in_data, in_eol, out_ready,
    output out_valid, out_data, out_eol
  );
endinterface

// File: rtl/line_pingpong_ctrl.sv
// Ping-pong line buffer controller over a 2-bank SDP RAM (bank = address MSB).
// Optional LINE_PINGPONG_REPEAT_EN adds rd_repeat_i to replay each line once drained.
module line_pingpong_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  line_pingpong_if.slave    px,
`ifdef LINE_PINGPONG_REPEAT_EN
  input  logic              rd_repeat_i,
`endif
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic              line_drop_o,
  output logic              overflow_o
);
  localparam int CW = ADDR_W - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, START, READ, DRAIN} st_e;

  st_e               state_q, state_d;
  logic              wr_bank_q, wr_bank_d, full_q, full_d, ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d, drop_q, drop_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              handoff, rd_free, rd_issue, rep;
  logic              rd_bank_q;
  logic [CW-1:0]     rd_last_q, rd_ptr_q, line_last;
  logic              infl_q, infl_eol_q;
  logic [1:0][DATA_W-1:0] fd_q;
  logic [1:0]        fe_q, fcnt_q;
  logic              wp_q, rp_q, pop, final_beat;
  logic [2:0]        occ;

`ifdef LINE_PINGPONG_REPEAT_EN
  assign rep = rd_repeat_i;
`else
  assign rep = 1'b0;
`endif

  assign pop        = (fcnt_q != 2'd0) && px.out_ready;
  assign final_beat = pop && fe_q[rp_q];
  // occupancy after this cycle's pop, so a steady stream issues every cycle
  assign occ        = {1'b0, fcnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign line_last  = full_q ? CNT_MAX : wr_cnt_q;

  // write side
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = 1'b0;
    handoff   = 1'b0;
    if (px.in_valid) begin
      if (full_q) ovf_d = 1'b1;
      else begin
        wr_en_d   = 1'b1;
        wr_addr_d = {wr_bank_q, wr_cnt_q};
        wr_data_d = px.in_data;
        if (wr_cnt_q == CNT_MAX) full_d = 1'b1;
        else wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (px.in_eol) begin
        wr_cnt_d = '0;
        full_d   = 1'b0;
        if (rd_free) begin
          handoff   = 1'b1;
          wr_bank_d = ~wr_bank_q;
        end else drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0; wr_cnt_q <= '0; full_q <= 1'b0; ovf_q <= 1'b0;
      wr_en_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0; drop_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d; wr_cnt_q <= wr_cnt_d; full_q <= full_d; ovf_q <= ovf_d;
      wr_en_q <= wr_en_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d; drop_q <= drop_d;
    end
  end

  // read FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (handoff) state_d = START;
      START: state_d = READ;
      READ:  if (rd_issue && (rd_ptr_q == rd_last_q)) state_d = DRAIN;
      DRAIN: if (final_beat) state_d = (handoff || rep) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_issue = (state_q == READ) && (occ < 3'd2);
    rd_free  = (state_q == IDLE) || (final_beat && !rep);
  end

  // read datapath and 2-entry skid FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0; rd_last_q <= '0; rd_ptr_q <= '0;
      infl_q <= 1'b0; infl_eol_q <= 1'b0;
      fd_q <= '0; fe_q <= '0; fcnt_q <= '0; wp_q <= 1'b0; rp_q <= 1'b0;
    end else begin
      if (handoff) begin
        rd_bank_q <= wr_bank_q;
        rd_last_q <= line_last;
      end
      if (rd_issue) rd_ptr_q <= (rd_ptr_q == rd_last_q) ? '0 : rd_ptr_q + 1'b1;
      infl_q     <= rd_issue;
      infl_eol_q <= rd_issue && (rd_ptr_q == rd_last_q);
      if (infl_q) begin
        fd_q[wp_q] <= ram_rd_data_i;
        fe_q[wp_q] <= infl_eol_q;
        wp_q       <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      fcnt_q <= fcnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign ram_rd_addr_o = {rd_bank_q, rd_ptr_q};
  assign line_drop_o   = drop_q;
  assign overflow_o    = ovf_q;
  assign px.out_valid  = (fcnt_q != 2'd0);
  assign px.out_data   = fd_q[rp_q];
  assign px.out_eol    = (fcnt_q != 2'd0) && fe_q[rp_q];
endmodule

// File: tb/tb_line_pingpong_ctrl.sv
// Directed + randomized bench for line_pingpong_ctrl with a RAM model and a
// line-level scoreboard of accepted/dropped lines.
module tb_line_pingpong_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int BANK   = 1 << (ADDR_W - 1);

  typedef struct { logic [7:0] d; logic eol; } pix_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_wr_en, line_drop, overflow;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  line_pingpong_if #(.DATA_W(DATA_W)) px ();

  line_pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .px(px),
`ifdef LINE_PINGPONG_REPEAT_EN
    .rd_repeat_i(1'b0),
`endif
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .line_drop_o(line_drop), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  pix_t       q[$];
  logic [7:0] cur[$];
  logic       m_bank = 1'b0, e_wr_en = 1'b0, e_drop = 1'b0, e_ovf = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [7:0] e_data = '0, prev_data = '0;
  logic       stall_prev = 1'b0, prev_valid = 1'b0, started = 1'b0;
  int cyc = 0, eol_cyc = 0, fv_cyc = 0, drop_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      logic beat, free;
      pix_t p;
      int n;
      cyc++;
      chk("wr_en", ram_wr_en, e_wr_en);
      if (e_wr_en) begin
        chk("wr_addr", ram_wr_addr, e_addr);
        chk("wr_data", ram_wr_data, e_data);
      end
      chk("line_drop", line_drop, e_drop);
      chk("overflow", overflow, e_ovf);
      if (line_drop) drop_cnt++;
      if (q.size() == 0) chk("idle_valid", px.out_valid, 1'b0);
      if (stall_prev) begin
        chk("stall_valid", px.out_valid, 1'b1);
        chk("stall_data", px.out_data, prev_data);
      end
      if (!prev_valid && px.out_valid) fv_cyc = cyc;
      beat = px.out_valid && px.out_ready;
      free = (q.size() == 0) || (beat && q.size() == 1);
      if (beat) begin
        if (q.size() == 0) chk("spurious_beat", 1'b1, 1'b0);
        else begin
          p = q.pop_front();
          chk("out_data", px.out_data, p.d);
          chk("out_eol", px.out_eol, p.eol);
        end
      end
      e_wr_en = 1'b0;
      e_drop  = 1'b0;
      if (!rst_n) begin
        q.delete(); cur.delete();
        m_bank = 1'b0; e_ovf = 1'b0; e_addr = '0; e_data = '0;
      end else if (px.in_valid) begin
        n = cur.size();
        if (n < BANK) begin
          e_wr_en = 1'b1;
          e_addr  = ADDR_W'(int'(m_bank) * BANK + n);
          e_data  = px.in_data;
          cur.push_back(px.in_data);
        end else e_ovf = 1'b1;
        if (px.in_eol) begin
          if (free) begin
            for (int i = 0; i < cur.size(); i++) begin
              p.d = cur[i]; p.eol = (i == cur.size() - 1);
              q.push_back(p);
            end
            m_bank  = ~m_bank;
            eol_cyc = cyc;
          end else e_drop = 1'b1;
          cur.delete();
        end
      end
      stall_prev = rst_n && px.out_valid && !px.out_ready;
      prev_data  = px.out_data;
      prev_valid = px.out_valid;
    end
  end

  // stimulus helpers: out_ready follows rdy_mode each cycle
  int rdy_mode = 0, phase = 0;

  task automatic tick();
    @(posedge clk); #1;
    phase++;
    case (rdy_mode)
      0: px.out_ready = 1'b1;
      1: px.out_ready = 1'b0;
      2: px.out_ready = (phase % 3 == 0);
      default: px.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_line(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tick();
      px.in_valid = 1'b1;
      px.in_data  = rnd ? 8'($urandom) : 8'(base + i);
      px.in_eol   = (i == n - 1);
    end
    tick();
    px.in_valid = 1'b0;
    px.in_eol   = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin tick(); n++; end
    chk("drain_timeout", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    rst_n = 1'b0; px.in_valid = 1'b0; px.in_data = '0; px.in_eol = 1'b0; px.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wr_en", ram_wr_en, 1'b0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_wr_data", ram_wr_data, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    chk("rst_out_valid", px.out_valid, 1'b0);
    chk("rst_out_data", px.out_data, 0);
    chk("rst_out_eol", px.out_eol, 1'b0);
    chk("rst_line_drop", line_drop, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    tick();
    rst_n = 1'b1;
    started = 1'b1;

    // single 4-pixel line, latency, then second line into bank 1
    rdy_mode = 0;
    send_line(4, 8'h10, 1'b0);
    wait_drain(100);
    chk("first_valid_latency", fv_cyc - eol_cyc, 4);
    send_line(4, 8'h20, 1'b0);
    wait_drain(100);

    // back-to-back lines; second eol coincides with first line's final beat
    d0 = drop_cnt;
    send_line(8, 8'h30, 1'b0);
    repeat (2) tick();
    send_line(8, 8'h40, 1'b0);
    wait_drain(200);
    chk("b2b_drops", drop_cnt - d0, 0);

    // stalled reader forces a drop; first line survives
    d0 = drop_cnt;
    rdy_mode = 1;
    send_line(8, 8'h50, 1'b0);
    repeat (5) tick();
    send_line(8, 8'h60, 1'b0);
    repeat (5) tick();
    chk("stall_drops", drop_cnt - d0, 1);
    rdy_mode = 0;
    wait_drain(200);

    // 1,0,0 output stalls across a 16-pixel line
    rdy_mode = 2;
    send_line(16, 0, 1'b1);
    wait_drain(400);

    // overlong line clamps to bank size
    rdy_mode = 0;
    send_line(1100, 0, 1'b1);
    wait_drain(3000);
    chk("overflow_sticky", overflow, 1'b1);

    // reset while reading; partial line lost, next line from bank 0
    send_line(16, 8'h70, 1'b0);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", px.out_valid, 1'b0);
    chk("post_rst_wr_en", ram_wr_en, 1'b0);
    chk("post_rst_overflow", overflow, 1'b0);
    send_line(2, 8'hA0, 1'b0);
    wait_drain(100);

    // randomized lines, gaps and backpressure
    rdy_mode = 3;
    for (int k = 0; k < 15; k++) begin
      send_line($urandom_range(1, 40), 0, 1'b1);
      repeat ($urandom_range(0, 6)) tick();
    end
    rdy_mode = 0;
    wait_drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
